// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle path.
package twiddle_pkg;

  localparam int TW_WIDTH = 16;
  localparam int Q_FRAC   = TW_WIDTH - 1;

  typedef struct packed {
    logic signed [TW_WIDTH-1:0] re;
    logic signed [TW_WIDTH-1:0] im;
  } twiddle_t;

  // round(cos(pi*i/(n/2)) * 2^(w-1)), saturated to the positive maximum.
  // Taylor series keeps this usable as a constant function in any tool.
  function automatic int cos_q(input int i, input int n, input int w);
    real x, term, sum, scale;
    int  r;
    x     = 3.14159265358979323846 * real'(i) / real'(n / 2);
    term  = 1.0;
    sum   = 1.0;
    for (int t = 1; t <= 14; t++) begin
      term = -term * x * x / real'((2 * t - 1) * (2 * t));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int b = 0; b < w - 1; b++) scale = scale * 2.0;
    r = $rtoi(sum * scale + 0.5);
    if (r > (1 << (w - 1)) - 1) r = (1 << (w - 1)) - 1;
    if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table with two combinational read ports.
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  localparam int Q         = N / 4,
  localparam int IDX_W     = $clog2(Q + 1)
) (
  input  logic [IDX_W-1:0]             idx_a,
  input  logic [IDX_W-1:0]             idx_b,
  output logic signed [DATA_WIDTH-1:0] data_a,
  output logic signed [DATA_WIDTH-1:0] data_b
);

  logic signed [DATA_WIDTH-1:0] rom_q [Q+1];

  for (genvar i = 0; i <= Q; i++) begin : g_rom
    localparam int CV = cos_q(i, N, DATA_WIDTH);
    assign rom_q[i] = DATA_WIDTH'(CV);
  end

  // Indices above Q never come out of the fold; return zero to keep reads defined.
  assign data_a = (idx_a <= IDX_W'(Q)) ? rom_q[idx_a] : '0;
  assign data_b = (idx_b <= IDX_W'(Q)) ? rom_q[idx_b] : '0;

endmodule

// File: rtl/twiddle_rom_reader.sv
// Pointer k -> W_N^k = cos - j*sin, 3-stage pipeline: fold, quarter-ROM read, sign.
module twiddle_rom_reader
  import twiddle_pkg::*;
#(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int PTR_WIDTH  = $clog2(N) - 1,
  parameter int TAG_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         valid_in,
  input  logic [PTR_WIDTH-1:0]         pointer_in,
  input  logic [TAG_WIDTH-1:0]         tag_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] twiddle_re,
  output logic signed [DATA_WIDTH-1:0] twiddle_im,
  output logic [TAG_WIDTH-1:0]         tag_out
);

  localparam int Q     = N / 4;
  localparam int IDX_W = $clog2(Q + 1);
  localparam int LO_W  = PTR_WIDTH - 1;

  logic [3:1] vld_pipe;

  // S1: fold the half-circle pointer onto the quarter table
  logic             quad;
  logic [IDX_W-1:0] k_lo, q_c, fold_a, fold_b;

  assign quad   = pointer_in[PTR_WIDTH-1];
  assign k_lo   = IDX_W'(pointer_in[LO_W-1:0]);
  assign q_c    = IDX_W'(Q);
  assign fold_a = quad ? (q_c - k_lo) : k_lo;
  assign fold_b = quad ? k_lo : (q_c - k_lo);

  logic [IDX_W-1:0]     idx_a1, idx_b1;
  logic                 neg1;
  logic [TAG_WIDTH-1:0] tag1;

  // S2: table reads
  logic signed [DATA_WIDTH-1:0] rd_a, rd_b, ca2, cb2;
  logic                         neg2;
  logic [TAG_WIDTH-1:0]         tag2;

  twiddle_quarter_rom #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .idx_a  (idx_a1),
    .idx_b  (idx_b1),
    .data_a (rd_a),
    .data_b (rd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      idx_a1     <= '0;
      idx_b1     <= '0;
      neg1       <= 1'b0;
      tag1       <= '0;
      ca2        <= '0;
      cb2        <= '0;
      neg2       <= 1'b0;
      tag2       <= '0;
      twiddle_re <= '0;
      twiddle_im <= '0;
      tag_out    <= '0;
    end else if (enable) begin
      vld_pipe   <= {vld_pipe[2:1], valid_in};
      idx_a1     <= fold_a;
      idx_b1     <= fold_b;
      neg1       <= quad;
      tag1       <= tag_in;
      ca2        <= rd_a;
      cb2        <= rd_b;
      neg2       <= neg1;
      tag2       <= tag1;
      // S3: |C| never exceeds the positive max, so negation cannot overflow
      twiddle_re <= neg2 ? -ca2 : ca2;
      twiddle_im <= -cb2;
      tag_out    <= tag2;
    end
  end

  assign valid_out = vld_pipe[3];

endmodule

// File: tb/tb_twiddle_rom_reader.sv
// Randomized and directed bench for twiddle_rom_reader (N=16, 16-bit twiddles).
module tb_twiddle_rom_reader;
  import twiddle_pkg::*;

  localparam int  N  = 16;
  localparam int  DW = 16;
  localparam int  PW = 3;
  localparam int  TW = 2;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 reset, enable, valid_in;
  logic [PW-1:0]        pointer_in;
  logic [TW-1:0]        tag_in;
  logic                 valid_out;
  logic signed [DW-1:0] twiddle_re, twiddle_im;
  logic [TW-1:0]        tag_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int k;
    int tag;
  } ent_t;
  ent_t hist[$];

  twiddle_t sweep_exp [8] = '{32'h7FFF_0000, 32'h7642_CF04, 32'h5A82_A57E, 32'h30FC_89BE,
                              32'h0000_8001, 32'hCF04_89BE, 32'hA57E_A57E, 32'h89BE_CF04};

  twiddle_rom_reader #(.N(N), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .valid_in   (valid_in),
    .pointer_in (pointer_in),
    .tag_in     (tag_in),
    .valid_out  (valid_out),
    .twiddle_re (twiddle_re),
    .twiddle_im (twiddle_im),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int clampq(input int r);
    if (r > 32767) return 32767;
    if (r < -32767) return -32767;
    return r;
  endfunction

  function automatic int ref_re(input int k);
    return clampq(rnd($cos(2.0 * PI * real'(k) / real'(N)) * 32768.0));
  endfunction

  function automatic int ref_im(input int k);
    return clampq(rnd(-$sin(2.0 * PI * real'(k) / real'(N)) * 32768.0));
  endfunction

  // One clock: drive, let the edge happen, update the latency model, sample 1ns later.
  task automatic cyc(input bit rst, input bit en, input bit v, input int k, input int t);
    ent_t e;
    reset = rst; enable = en; valid_in = v;
    pointer_in = PW'(k); tag_in = TW'(t);
    @(posedge clk);
    if (rst) begin
      hist.delete();
      e.v = 0; e.k = 0; e.tag = 0;
      repeat (3) hist.push_back(e);
    end else if (en) begin
      e.v = v; e.k = k; e.tag = t;
      hist.push_front(e);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 5, 3);
    cyc(1, 1, 1, 6, 2);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (twiddle_re !== 16'sd0) begin errors++; $display("FAIL reset_re got %h want 0000", twiddle_re); end
    checks++; if (twiddle_im !== 16'sd0) begin errors++; $display("FAIL reset_im got %h want 0000", twiddle_im); end
    checks++; if (tag_out !== 2'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", tag_out); end
    cyc(0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc(0, 1, 0, 0, 0);
      if (i < 2) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL first_latency cyc %0d valid got %b want 0", i, valid_out); end
      end
    end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", valid_out); end
    checks++; if (twiddle_re !== 16'sh7FFF || twiddle_im !== 16'sh0000 || tag_out !== 2'd1) begin
      errors++; $display("FAIL first_data got (%h,%h,%0d) want (7fff,0000,1)", twiddle_re, twiddle_im, tag_out);
    end
    repeat (2) cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_sweep();
    int nout = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) cyc(0, 1, 1, i, i % 4);
      else       cyc(0, 1, 0, 0, 0);
      checks++;
      if (valid_out !== ((i >= 2 && i <= 9) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL sweep_valid cyc %0d got %b", i, valid_out);
      end else if (valid_out) begin
        checks++;
        if (twiddle_re !== sweep_exp[nout].re || twiddle_im !== sweep_exp[nout].im || tag_out !== TW'(nout % 4)) begin
          errors++; $display("FAIL sweep_data k=%0d got (%h,%h,%0d) want (%h,%h,%0d)", nout,
                             twiddle_re, twiddle_im, tag_out, sweep_exp[nout].re, sweep_exp[nout].im, nout % 4);
        end
        nout++;
      end
    end
    checks++; if (nout != 8) begin errors++; $display("FAIL sweep_count got %0d want 8", nout); end
  endtask

  task automatic test_stall();
    int got_tag[$];
    int got_re[$];
    logic                 s_v;
    logic signed [DW-1:0] s_re, s_im;
    logic [TW-1:0]        s_tag;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, i + 1, i + 1);
      if (valid_out) begin got_tag.push_back(int'(tag_out)); got_re.push_back(int'(twiddle_re)); end
    end
    s_v = valid_out; s_re = twiddle_re; s_im = twiddle_im; s_tag = tag_out;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 3));
      checks++;
      if (valid_out !== s_v || twiddle_re !== s_re || twiddle_im !== s_im || tag_out !== s_tag) begin
        errors++; $display("FAIL stall_hold cyc %0d got (%b,%h,%h,%0d) want (%b,%h,%h,%0d)", i,
                           valid_out, twiddle_re, twiddle_im, tag_out, s_v, s_re, s_im, s_tag);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (valid_out) begin got_tag.push_back(int'(tag_out)); got_re.push_back(int'(twiddle_re)); end
    end
    checks++;
    if (got_tag.size() != 3) begin
      errors++; $display("FAIL stall_count got %0d want 3", got_tag.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_tag[i] != i + 1 || got_re[i] != ref_re(i + 1)) begin
          errors++; $display("FAIL stall_order idx %0d got (tag %0d, re %0d) want (tag %0d, re %0d)",
                             i, got_tag[i], got_re[i], i + 1, ref_re(i + 1));
        end
      end
    end
  endtask

  task automatic test_bubbles();
    bit ev [7] = '{0, 0, 1, 0, 1, 1, 0};
    int ek [7] = '{0, 0, 4, 0, 6, 7, 0};
    int et [7] = '{0, 0, 1, 0, 2, 3, 0};
    bit vin [4] = '{1, 0, 1, 1};
    int kin [4] = '{4, 0, 6, 7};
    int tin [4] = '{1, 0, 2, 3};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) cyc(0, 1, vin[i], (i == 1) ? int'($urandom_range(0, 7)) : kin[i], tin[i]);
      else       cyc(0, 1, 0, 0, 0);
      checks++;
      if (valid_out !== ev[i]) begin
        errors++; $display("FAIL bubble_valid cyc %0d got %b want %b", i, valid_out, ev[i]);
      end else if (ev[i]) begin
        checks++;
        if (int'(twiddle_re) != ref_re(ek[i]) || int'(twiddle_im) != ref_im(ek[i]) || int'(tag_out) != et[i]) begin
          errors++; $display("FAIL bubble_data cyc %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                             twiddle_re, twiddle_im, tag_out, ref_re(ek[i]), ref_im(ek[i]), et[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, $urandom_range(0, 7), $urandom_range(1, 3));
    cyc(1, 0, 1, 3, 3);
    checks++;
    if (valid_out !== 1'b0 || twiddle_re !== 16'sd0 || twiddle_im !== 16'sd0 || tag_out !== 2'd0) begin
      errors++; $display("FAIL midreset_clear got (%b,%h,%h,%0d) want (0,0000,0000,0)",
                         valid_out, twiddle_re, twiddle_im, tag_out);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, 0);
      checks++;
      if (valid_out !== 1'b0) begin errors++; $display("FAIL midreset_stale cyc %0d got %b want 0", i, valid_out); end
    end
  endtask

  // Emulates a pointer generator stepping by STEP on each accepted sample.
  task automatic test_random();
    int steps [3] = '{1, 2, 4};
    int ptr = 0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 150; c++) begin
        bit en, v;
        int t, dr, di;
        en = ($urandom_range(0, 3) != 0);
        v  = ($urandom_range(0, 7) != 0);
        t  = $urandom_range(0, 3);
        cyc(0, en, v, ptr, t);
        if (en && v) ptr = (ptr + steps[s]) % (N / 2);
        checks++;
        if (valid_out !== hist[2].v) begin
          errors++; $display("FAIL rand_valid step %0d cyc %0d got %b want %b", steps[s], c, valid_out, hist[2].v);
        end else if (hist[2].v) begin
          dr = int'(twiddle_re) - ref_re(hist[2].k);
          di = int'(twiddle_im) - ref_im(hist[2].k);
          checks++;
          if (dr > 1 || dr < -1 || di > 1 || di < -1 || int'(tag_out) != hist[2].tag) begin
            errors++; $display("FAIL rand_data k=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", hist[2].k,
                               twiddle_re, twiddle_im, tag_out, ref_re(hist[2].k), ref_im(hist[2].k), hist[2].tag);
          end
        end
      end
    end
    repeat (3) cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; valid_in = 1'b0; pointer_in = '0; tag_in = '0;
    @(posedge clk); #1;
    test_reset();
    test_sweep();
    test_stall();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
